// File: rtl/primitive_assembler.sv
// Groups fetched vertices into triangles (3 payloads out); tri valid 1 cycle after 3rd vertex; accept and emit never overlap.
// Define PRIM_ASM_STRIP_EN to add strip-mode assembly via i_strip_mode.
module primitive_assembler #(
  parameter int VERTEX_WIDTH = 256,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_draw_start,
  input  logic [COUNT_WIDTH-1:0]  i_vertex_count,
`ifdef PRIM_ASM_STRIP_EN
  input  logic                    i_strip_mode,
`endif
  output logic                    o_busy,
  input  logic                    i_vtx_valid,
  output logic                    o_vtx_ready,
  input  logic [VERTEX_WIDTH-1:0] i_vtx_data,
  output logic                    o_tri_valid,
  input  logic                    i_tri_ready,
  output logic [VERTEX_WIDTH-1:0] o_tri_v0,
  output logic [VERTEX_WIDTH-1:0] o_tri_v1,
  output logic [VERTEX_WIDTH-1:0] o_tri_v2,
  output logic                    o_tri_last,
  output logic                    o_draw_done
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  remain_q, remain_d;
  logic [1:0]              idx_q, idx_d;
  logic [VERTEX_WIDTH-1:0] slot_q [3];
  logic [VERTEX_WIDTH-1:0] slot_d [3];
  logic                    odd_q, odd_d;
  logic                    swap;

`ifdef PRIM_ASM_STRIP_EN
  logic strip_q, strip_d;
`else
  logic strip_q;
  assign strip_q = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    idx_d       = idx_q;
    slot_d      = slot_q;
    odd_d       = odd_q;
`ifdef PRIM_ASM_STRIP_EN
    strip_d     = strip_q;
`endif
    o_busy      = (state_q != IDLE);
    o_vtx_ready = 1'b0;
    o_tri_valid = 1'b0;
    o_tri_last  = 1'b0;
    o_draw_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_draw_start) begin
          remain_d = i_vertex_count;
          idx_d    = 2'd0;
          odd_d    = 1'b0;
`ifdef PRIM_ASM_STRIP_EN
          strip_d  = i_strip_mode;
`endif
          state_d  = (i_vertex_count == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        o_vtx_ready = 1'b1;
        if (i_vtx_valid) begin
          case (idx_q)
            2'd0:    slot_d[0] = i_vtx_data;
            2'd1:    slot_d[1] = i_vtx_data;
            default: slot_d[2] = i_vtx_data;
          endcase
          remain_d = remain_q - COUNT_WIDTH'(1);
          if (idx_q == 2'd2) begin
            state_d = EMIT;
          end else begin
            idx_d = idx_q + 2'd1;
            // Draw exhausted before a full triangle: trailing vertices are dropped.
            if (remain_q == COUNT_WIDTH'(1)) state_d = DONE;
          end
        end
      end
      EMIT: begin
        o_tri_valid = 1'b1;
        o_tri_last  = (remain_q == '0);
        if (i_tri_ready) begin
          odd_d = ~odd_q;
          if (remain_q == '0) begin
            state_d = DONE;
          end else begin
            state_d = COLLECT;
            if (strip_q) begin
              // Strip reuses the last two vertices; only slot 2 is refilled.
              slot_d[0] = slot_q[1];
              slot_d[1] = slot_q[2];
              slot_d[2] = '0;
              idx_d     = 2'd2;
            end else begin
              slot_d[0] = '0;
              slot_d[1] = '0;
              slot_d[2] = '0;
              idx_d     = 2'd0;
            end
          end
        end
      end
      DONE: begin
        o_draw_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Odd strip triangles swap v0/v1 to keep a consistent winding.
  assign swap     = strip_q & odd_q;
  assign o_tri_v0 = swap ? slot_q[1] : slot_q[0];
  assign o_tri_v1 = swap ? slot_q[0] : slot_q[1];
  assign o_tri_v2 = slot_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      remain_q  <= '0;
      idx_q     <= 2'd0;
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      slot_q[2] <= '0;
      odd_q     <= 1'b0;
`ifdef PRIM_ASM_STRIP_EN
      strip_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      idx_q     <= idx_d;
      slot_q    <= slot_d;
      odd_q     <= odd_d;
`ifdef PRIM_ASM_STRIP_EN
      strip_q   <= strip_d;
`endif
    end
  end

endmodule
